// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: registered arbiter/sequencer between the cache controllers
// and the single AXI memory port. One block transaction at a time; fixed
// priority writeback > dcache refill > icache refill.
// Optional watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_mem_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int BLOCK_WIDTH    = 512,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_wb_req,
   input  logic [ADDR_WIDTH-1:0]  i_wb_addr,
   input  logic [BLOCK_WIDTH-1:0] i_wb_data,
   input  logic                   i_rd_d_req,
   input  logic [ADDR_WIDTH-1:0]  i_rd_d_addr,
   input  logic                   i_rd_i_req,
   input  logic [ADDR_WIDTH-1:0]  i_rd_i_addr,
   input  logic                   i_axi_done,
   input  logic [BLOCK_WIDTH-1:0] i_data_block,
   output logic [ADDR_WIDTH-1:0]  o_axi_addr,
   output logic [BLOCK_WIDTH-1:0] o_data_block,
   output logic                   o_axi_write_start,
   output logic                   o_axi_read_start,
   output logic                   o_wb_done,
   output logic                   o_rd_d_done,
   output logic                   o_rd_i_done,
   output logic [BLOCK_WIDTH-1:0] o_rd_data,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_D,
      S_RD_I,
      S_RESP
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   state_t                 r_last;      // transaction kind, selects the done pulse in RESP
   logic [ADDR_WIDTH-1:0]  r_axi_addr;
   logic [BLOCK_WIDTH-1:0] r_wdata;
   logic [BLOCK_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0]  w_sel_addr;
   logic                   w_in_xfer;
   logic                   w_in_read;
   logic                   w_timeout_hit;

   assign w_in_xfer = (r_state == S_WR) || (r_state == S_RD_D) || (r_state == S_RD_I);
   assign w_in_read = (r_state == S_RD_D) || (r_state == S_RD_I);

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   // Hitting the last count with no done aborts the transaction into RESP.
   assign w_timeout_hit = w_in_xfer && !i_axi_done && (r_cnt == CNT_LAST);

   // Watchdog: held at zero in IDLE so every transaction starts from zero.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_IDLE)
            r_cnt <= '0;
         else if (w_in_xfer && !w_timeout_hit)
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_timeout_hit)
            r_timeout <= 1'b1;
      end
   end

   assign o_timeout = r_timeout;
`else
   logic w_unused_cfg;

   assign w_unused_cfg  = (TIMEOUT_CYCLES != 0);
   assign w_timeout_hit = 1'b0;
   assign o_timeout     = 1'b0;
`endif

   // Request address selection, same priority as the grant.
   always_comb begin
      w_sel_addr = '0;
      if (i_wb_req)
         w_sel_addr = i_wb_addr;
      else if (i_rd_d_req)
         w_sel_addr = i_rd_d_addr;
      else if (i_rd_i_req)
         w_sel_addr = i_rd_i_addr;
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic: grant in IDLE, wait for done (or watchdog), one RESP cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_wb_req)
               w_next = S_WR;
            else if (i_rd_d_req)
               w_next = S_RD_D;
            else if (i_rd_i_req)
               w_next = S_RD_I;
         end
         S_WR, S_RD_D, S_RD_I: begin
            if (i_axi_done || w_timeout_hit)
               w_next = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: capture address/write data at grant, read data on done.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_axi_addr <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_last     <= S_IDLE;
      end else begin
         if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
            r_axi_addr <= w_sel_addr & ADDR_MASK;
            r_last     <= w_next;
            if (w_next == S_WR)
               r_wdata <= i_wb_data;
         end
         if (w_in_read && i_axi_done)
            r_rdata <= i_data_block;
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      o_axi_write_start = (r_state == S_WR);
      o_axi_read_start  = w_in_read;
      o_wb_done         = (r_state == S_RESP) && (r_last == S_WR);
      o_rd_d_done       = (r_state == S_RESP) && (r_last == S_RD_D);
      o_rd_i_done       = (r_state == S_RESP) && (r_last == S_RD_I);
      o_busy            = (r_state != S_IDLE);
      o_axi_addr        = r_axi_addr;
      o_data_block      = r_wdata;
      o_rd_data         = r_rdata;
   end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Testbench for axi_mem_arbiter: directed scenarios followed by a randomized
// phase, all checked against a transaction-level reference model.
module tb_axi_mem_arbiter;

   localparam int AW = 64;
   localparam int BW = 512;
   localparam int TO = 16;
`ifdef AXI_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          i_arst = 1'b1;
   logic          i_wb_req = 1'b0;
   logic [AW-1:0] i_wb_addr = '0;
   logic [BW-1:0] i_wb_data = '0;
   logic          i_rd_d_req = 1'b0;
   logic [AW-1:0] i_rd_d_addr = '0;
   logic          i_rd_i_req = 1'b0;
   logic [AW-1:0] i_rd_i_addr = '0;
   logic          i_axi_done = 1'b0;
   logic [BW-1:0] i_data_block = '0;
   logic [AW-1:0] o_axi_addr;
   logic [BW-1:0] o_data_block;
   logic          o_axi_write_start, o_axi_read_start;
   logic          o_wb_done, o_rd_d_done, o_rd_i_done;
   logic [BW-1:0] o_rd_data;
   logic          o_busy, o_timeout;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: active kind (0 none, 1 wb, 2 dcache, 3 icache),
   // kind being acknowledged this cycle, cycles spent waiting.
   int            m_act, m_resp, m_cnt;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_wdata, m_rdata;
   logic          m_tmo;

   axi_mem_arbiter #(
      .ADDR_WIDTH(AW),
      .BLOCK_WIDTH(BW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk),
      .i_arst(i_arst),
      .i_wb_req(i_wb_req),
      .i_wb_addr(i_wb_addr),
      .i_wb_data(i_wb_data),
      .i_rd_d_req(i_rd_d_req),
      .i_rd_d_addr(i_rd_d_addr),
      .i_rd_i_req(i_rd_i_req),
      .i_rd_i_addr(i_rd_i_addr),
      .i_axi_done(i_axi_done),
      .i_data_block(i_data_block),
      .o_axi_addr(o_axi_addr),
      .o_data_block(o_data_block),
      .o_axi_write_start(o_axi_write_start),
      .o_axi_read_start(o_axi_read_start),
      .o_wb_done(o_wb_done),
      .o_rd_d_done(o_rd_d_done),
      .o_rd_i_done(o_rd_i_done),
      .o_rd_data(o_rd_data),
      .o_busy(o_busy),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] b;
      for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
      return b;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act   = 0;
      m_resp  = 0;
      m_cnt   = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
      m_tmo   = 1'b0;
   endtask

   // One clock edge of the specified behaviour, evaluated on the inputs
   // present at that edge.
   task automatic model_step();
      if (i_arst) begin
         model_reset();
         return;
      end
      if (m_resp != 0) begin
         m_resp = 0;
      end else if (m_act == 0) begin
         m_cnt = 0;
         if (i_wb_req) begin
            m_act   = 1;
            m_addr  = i_wb_addr & ~64'h3f;
            m_wdata = i_wb_data;
         end else if (i_rd_d_req) begin
            m_act  = 2;
            m_addr = i_rd_d_addr & ~64'h3f;
         end else if (i_rd_i_req) begin
            m_act  = 3;
            m_addr = i_rd_i_addr & ~64'h3f;
         end
      end else if (i_axi_done) begin
         if (m_act != 1) m_rdata = i_data_block;
         m_resp = m_act;
         m_act  = 0;
      end else if (TMO_EN && (m_cnt + 1 == TO)) begin
         m_tmo  = 1'b1;
         m_resp = m_act;
         m_act  = 0;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/addr"}, BW'(o_axi_addr), BW'(m_addr));
      chk({tag, "/wdata"}, o_data_block, m_wdata);
      chk({tag, "/wstart"}, BW'(o_axi_write_start), BW'(m_act == 1));
      chk({tag, "/rstart"}, BW'(o_axi_read_start), BW'(m_act >= 2));
      chk({tag, "/wb_done"}, BW'(o_wb_done), BW'(m_resp == 1));
      chk({tag, "/rd_d_done"}, BW'(o_rd_d_done), BW'(m_resp == 2));
      chk({tag, "/rd_i_done"}, BW'(o_rd_i_done), BW'(m_resp == 3));
      chk({tag, "/rdata"}, o_rd_data, m_rdata);
      chk({tag, "/busy"}, BW'(o_busy), BW'((m_act != 0) || (m_resp != 0)));
      chk({tag, "/timeout"}, BW'(o_timeout), BW'(m_tmo));
   endtask

   // Advance one cycle, check everything, then act as the requesters:
   // done is a one-cycle pulse, and a requester drops its level on its done.
   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      i_axi_done = 1'b0;
      if (m_resp == 1) i_wb_req = 1'b0;
      if (m_resp == 2) i_rd_d_req = 1'b0;
      if (m_resp == 3) i_rd_i_req = 1'b0;
   endtask

   task automatic pulse_done(input string tag, output logic [BW-1:0] blk);
      blk          = rand_blk();
      i_data_block = blk;
      i_axi_done   = 1'b1;
      tick(tag);
   endtask

   logic [BW-1:0] blk, blk2, wd_a;

   initial begin
      model_reset();

      // Reset with an icache request already pending.
      i_arst      = 1'b1;
      i_rd_i_req  = 1'b1;
      i_rd_i_addr = 64'h1000_0047;
      @(posedge clk);
      #1;
      check_all("reset");
      i_arst = 1'b0;

      // 1: grant after release, done five cycles later.
      tick("t1_grant");
      chk("t1_addr", BW'(o_axi_addr), BW'(64'h1000_0040));
      chk("t1_rstart", BW'(o_axi_read_start), BW'(1));
      repeat (4) tick("t1_wait");
      pulse_done("t1_done", blk);
      chk("t1_done_pulse", BW'(o_rd_i_done), BW'(1));
      chk("t1_rdata", o_rd_data, blk);
      tick("t1_idle");
      chk("t1_single_pulse", BW'(o_rd_i_done), BW'(0));

      // 2: all three requests at once -> WR, RD_D, RD_I.
      wd_a        = rand_blk();
      i_wb_data   = wd_a;
      i_wb_addr   = 64'h2000_0011;
      i_rd_d_addr = 64'h3000_0022;
      i_rd_i_addr = 64'h4000_0033;
      i_wb_req    = 1'b1;
      i_rd_d_req  = 1'b1;
      i_rd_i_req  = 1'b1;
      tick("t2_wr");
      chk("t2_wr_start", BW'(o_axi_write_start), BW'(1));
      chk("t2_wr_addr", BW'(o_axi_addr), BW'(64'h2000_0000));
      i_wb_data = rand_blk();
      i_wb_addr = 64'h5555_0000;
      repeat (2) tick("t2_wr_wait");
      chk("t2_wdata_frozen", o_data_block, wd_a);
      pulse_done("t2_wr_done", blk);
      chk("t2_wb_done", BW'(o_wb_done), BW'(1));
      tick("t2_idle1");
      tick("t2_rdd");
      chk("t2_rdd_addr", BW'(o_axi_addr), BW'(64'h3000_0000));
      chk("t2_rdd_wstart", BW'(o_axi_write_start), BW'(0));
      pulse_done("t2_rdd_done", blk);
      tick("t2_idle2");
      tick("t2_rdi");
      chk("t2_rdi_addr", BW'(o_axi_addr), BW'(64'h4000_0000));
      pulse_done("t2_rdi_done", blk);
      tick("t2_idle3");

      // 3: done in IDLE and in RESP is ignored.
      i_axi_done = 1'b1;
      tick("t3_done_idle");
      chk("t3_idle_busy", BW'(o_busy), BW'(0));
      i_rd_d_req  = 1'b1;
      i_rd_d_addr = 64'h6000_00ff;
      tick("t3_grant");
      pulse_done("t3_done", blk);
      i_data_block = rand_blk();
      i_axi_done   = 1'b1;
      tick("t3_done_resp");
      chk("t3_rdata_kept", o_rd_data, blk);
      chk("t3_no_pulse", BW'(o_rd_d_done), BW'(0));
      tick("t3_idle");

      // 4: async reset three cycles into RD_D, request still high.
      i_rd_d_req  = 1'b1;
      i_rd_d_addr = 64'h7000_0080;
      tick("t4_grant");
      repeat (3) tick("t4_wait");
      i_arst = 1'b1;
      #1;
      model_reset();
      check_all("t4_async");
      chk("t4_rstart_zero", BW'(o_axi_read_start), BW'(0));
      tick("t4_hold");
      i_arst = 1'b0;
      tick("t4_regrant");
      chk("t4_regrant_start", BW'(o_axi_read_start), BW'(1));
      chk("t4_regrant_addr", BW'(o_axi_addr), BW'(64'h7000_0080));
      pulse_done("t4_done", blk);
      tick("t4_idle");

      // 5: request withdrawn one cycle after grant still completes.
      i_rd_i_req  = 1'b1;
      i_rd_i_addr = 64'h8000_0123;
      tick("t5_grant");
      i_rd_i_req = 1'b0;
      repeat (2) tick("t5_wait");
      pulse_done("t5_done", blk);
      chk("t5_done_pulse", BW'(o_rd_i_done), BW'(1));
      tick("t5_idle");

`ifdef AXI_ARB_TIMEOUT_EN
      // 6: watchdog aborts a transaction that never completes.
      blk2        = o_rd_data;
      i_rd_d_req  = 1'b1;
      i_rd_d_addr = 64'h9000_0000;
      tick("t6_grant");
      repeat (15) tick("t6_wait");
      chk("t6_still_waiting", BW'(o_axi_read_start), BW'(1));
      tick("t6_expire");
      chk("t6_timeout", BW'(o_timeout), BW'(1));
      chk("t6_rstart_off", BW'(o_axi_read_start), BW'(0));
      chk("t6_done_pulse", BW'(o_rd_d_done), BW'(1));
      chk("t6_rdata_kept", o_rd_data, blk2);
      tick("t6_idle");
      i_wb_req  = 1'b1;
      i_wb_addr = 64'ha000_0000;
      tick("t6_wr");
      pulse_done("t6_wr_done", blk);
      chk("t6_sticky", BW'(o_timeout), BW'(1));
      tick("t6_idle2");
`endif

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         if (!i_wb_req && ($urandom % 8 == 0)) begin
            i_wb_req  = 1'b1;
            i_wb_addr = rand_addr();
            i_wb_data = rand_blk();
         end
         if (!i_rd_d_req && ($urandom % 6 == 0)) begin
            i_rd_d_req  = 1'b1;
            i_rd_d_addr = rand_addr();
         end
         if (!i_rd_i_req && ($urandom % 5 == 0)) begin
            i_rd_i_req  = 1'b1;
            i_rd_i_addr = rand_addr();
         end else if (i_rd_i_req && ($urandom % 16 == 0)) begin
            i_rd_i_req = 1'b0;
         end
         if ($urandom % 4 == 0) i_wb_data = rand_blk();
         i_data_block = rand_blk();
         i_axi_done   = ($urandom % 4 == 0);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Registered arbiter and sequencer between the cache controllers and the single AXI memory port.
- Accepts three block-level requests: dcache writeback, dcache refill read and icache refill read.
- Grants one request at a time and holds the block-aligned address and write data stable for the whole transaction.
- Latches the returned block and returns a one-cycle done pulse to the granted requester.
- Replaces the combinational address/start muxing at top level.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- BLOCK_WIDTH, 512, cache block width in bits.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- i_clk  input  1  clock.
- i_arst  input  1  asynchronous active-high reset.
- i_wb_req  input  1  dcache writeback request (level).
- i_wb_addr  input  ADDR_WIDTH  writeback address.
- i_wb_data  input  BLOCK_WIDTH  writeback block.
- i_rd_d_req  input  1  dcache refill request (level).
- i_rd_d_addr  input  ADDR_WIDTH  dcache refill address.
- i_rd_i_req  input  1  icache refill request (level).
- i_rd_i_addr  input  ADDR_WIDTH  icache refill address.
- i_axi_done  input  1  AXI transaction complete (pulse).
- i_data_block  input  BLOCK_WIDTH  AXI read data, valid with i_axi_done.
- o_axi_addr  output  ADDR_WIDTH  block-aligned transaction address.
- o_data_block  output  BLOCK_WIDTH  write data to AXI.
- o_axi_write_start  output  1  write transaction active.
- o_axi_read_start  output  1  read transaction active.
- o_wb_done  output  1  writeback complete pulse.
- o_rd_d_done  output  1  dcache refill complete pulse.
- o_rd_i_done  output  1  icache refill complete pulse.
- o_rd_data  output  BLOCK_WIDTH  latched read block.
- o_busy  output  1  arbiter not in IDLE.
- o_timeout  output  1  sticky watchdog error (optional feature only; otherwise tied 0).

Behaviour:
- Reset: asynchronous, takes effect immediately. State IDLE; all outputs 0, including o_axi_addr, o_data_block and o_rd_data. Reset mid-transaction abandons the transaction with no done pulse.
- States:
  - IDLE: no transaction; picks the next request.
  - WR: writeback in progress.
  - RD_D: dcache refill in progress.
  - RD_I: icache refill in progress.
  - RESP: one-cycle completion state.
- IDLE, fixed priority when any request is high: i_wb_req > i_rd_d_req > i_rd_i_req.
  - Writeback must precede the refill of the same dirty line.
  - On grant: register the selected address into o_axi_addr with bits [$clog2(BLOCK_WIDTH/8)-1:0] forced to 0. This is 6 bits at the default.
  - On a writeback grant, also register i_wb_data into o_data_block.
  - Move to WR, RD_D or RD_I.
- WR: o_axi_write_start=1. RD_D and RD_I: o_axi_read_start=1.
  - Start is a level held from the first cycle in state until i_axi_done is sampled.
  - Address and write data are frozen for that whole interval.
- i_axi_done sampled high in WR, RD_D or RD_I:
  - Next cycle: state=RESP, start=0, and the matching o_*_done=1 for exactly one cycle.
  - For reads, o_rd_data = i_data_block captured on the done edge. o_rd_data holds until the next read completes.
- RESP: requests are ignored; go to IDLE unconditionally. The requester must drop its req during the done cycle.
  - Minimum turnaround: done edge → RESP → IDLE → grant in the next cycle. Back-to-back grants are therefore 2 cycles apart after the done edge.
- i_axi_done in IDLE or RESP: ignored.
- Request dropped before grant (e.g. icache request withdrawn on flush): never granted, no side effect.
- Request dropped after grant: the transaction still completes and the done pulse is still issued.
- Simultaneous requests: winner per the priority order. Losers stay pending and are re-evaluated in the next IDLE cycle. No starvation guarantee; the cache FSM protocol bounds request order.
- o_busy = (state != IDLE).

Optional Feature:
- Macro AXI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR, RD_D or RD_I and increments each busy cycle.
  - Reaching TIMEOUT_CYCLES without i_axi_done: set o_timeout (sticky until reset), deassert start, and go to RESP. The done pulse is issued with o_rd_data unchanged, so the pipeline does not hang.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; o_timeout tied 0; the arbiter waits indefinitely for i_axi_done.

Test Plan:
1. Reset with i_rd_i_req=1, i_rd_i_addr=0x1000_0047 → after release: grant; o_axi_addr=0x1000_0040, o_axi_read_start=1. Done 5 cycles later → o_rd_i_done pulses once and o_rd_data equals the driven block.
2. i_wb_req, i_rd_d_req and i_rd_i_req all rise in the same cycle → sequence is WR, RD_D, RD_I. o_axi_write_start=1 only during WR; o_data_block equals i_wb_data captured at grant, even if i_wb_data changes mid-transaction.
3. i_axi_done pulsed in IDLE and again in RESP → no state change and no done pulse.
4. i_arst asserted 3 cycles into RD_D → all outputs 0 immediately and no o_rd_d_done. After release with i_rd_d_req still high → fresh grant.
5. i_rd_i_req drops one cycle after grant → transaction completes; o_rd_i_done still pulses on done.
6. AXI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, no i_axi_done → at cycle 16: o_timeout=1, start=0, o_rd_d_done pulses. o_timeout stays 1 through later normal transactions.
